// File: rtl/pc_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns the PC and the instruction register and
// walks FETCH/DECODE/EXEC/UPDATE. Optional retired-instruction counter: PC_SEQ_CTRL_INSTRET_EN.
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic        exec_done,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        trap,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, ir_q, npc_q;
  logic        mis_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   if (exec_done) state_d = S_UPDATE;
      S_UPDATE: state_d = halt ? S_HALT : S_FETCH;
      S_HALT:   if (!halt) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: npc_q/mis_q are reset too, so an async reset mid-instruction cannot
  // leave a stale redirect waiting to be committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      npc_q <= RESET_PC;
      mis_q <= 1'b0;
    end else begin
      if (state_q == S_FETCH && imem_ack) ir_q <= imem_rdata;
      if (state_q == S_EXEC && exec_done) begin
        npc_q <= jump_en ? jump_target : pc_q + 32'd4;
        mis_q <= jump_en && (jump_target[1:0] != 2'b00);
      end
      if (state_q == S_UPDATE) pc_q <= mis_q ? TRAP_VEC : npc_q;
    end
  end

`ifdef PC_SEQ_CTRL_INSTRET_EN
  logic [31:0] instret_q;

  // Trapping instructions still retire, so every UPDATE counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     instret_q <= '0;
    else if (state_q == S_UPDATE) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = 32'h0;
`endif

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign ir_valid  = (state_q == S_DECODE);
  assign pc        = pc_q;
  assign state     = state_q;
  assign trap      = (state_q == S_UPDATE) && mis_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: the driver walks its own cycle timeline and
// queues expected results; a negedge monitor pops and compares them.
module tb_pc_seq_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_UPDATE = 3'd4, S_HALT = 3'd5;
  localparam logic [31:0] TRAP_VEC = 32'h0000_1000;

  typedef struct packed {
    logic        trap;
    logic [31:0] instret;
  } upd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, ir_valid, exec_done, jump_en, halt, trap;
  logic [31:0] imem_addr, imem_rdata, ir, jump_target, pc, instret;
  logic [2:0]  state;

  pc_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .ir_valid(ir_valid),
    .exec_done(exec_done), .jump_en(jump_en), .jump_target(jump_target), .halt(halt),
    .pc(pc), .state(state), .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        mon_en  = 1'b0;
  logic [2:0]  exp_state;
  logic [31:0] exp_pc;
  logic [31:0] ret_cnt;
  logic [31:0] addr_q[$];
  logic [31:0] ir_q[$];
  logic [31:0] halt_q[$];
  upd_t        upd_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction starting in its first FETCH cycle; leaves the bench in the next FETCH.
  task automatic do_instr(input int aw, input int dw, input logic j,
                          input logic [31:0] tgt, input int hc);
    logic [31:0] w;
    upd_t        u;
    addr_q.push_back(exp_pc);
    for (int i = 0; i < aw; i++) begin
      exp_state = S_FETCH; imem_ack = 1'b0; imem_rdata = $urandom; exec_done = 1'b1;
      step();
    end
    w = $urandom;
    exp_state = S_FETCH; imem_ack = 1'b1; imem_rdata = w; exec_done = 1'b1;
    ir_q.push_back(w);
    step();
    exp_state = S_DECODE; imem_ack = 1'b0; imem_rdata = $urandom; halt = 1'b1;
    step();
    halt = 1'b0;
    for (int i = 0; i < dw; i++) begin
      exp_state = S_EXEC; exec_done = 1'b0; jump_en = 1'b1; jump_target = 32'h0000_0003;
      step();
    end
    exp_state = S_EXEC; exec_done = 1'b1; jump_en = j; jump_target = tgt;
    u.trap = j && (tgt[1:0] != 2'b00);
`ifdef PC_SEQ_CTRL_INSTRET_EN
    u.instret = ret_cnt;
`else
    u.instret = 32'h0;
`endif
    exp_pc = u.trap ? TRAP_VEC : (j ? tgt : exp_pc + 32'd4);
    upd_q.push_back(u);
    step();
    exp_state = S_UPDATE; exec_done = 1'b0; jump_en = 1'b1; jump_target = $urandom;
    halt = (hc > 0);
    step();
    ret_cnt = ret_cnt + 32'd1;
    jump_en = 1'b0;
    for (int i = 0; i < hc; i++) begin
      exp_state = S_HALT; halt = (i < hc - 1);
      halt_q.push_back(exp_pc);
      step();
    end
    halt = 1'b0;
    exp_state = S_FETCH;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("state", {29'b0, state}, {29'b0, exp_state});
      case (exp_state)
        S_IDLE: begin
          check("idle_pc", pc, 32'h0);
          check("idle_ir", ir, 32'h0);
          check("idle_req", {31'b0, imem_req}, 32'h0);
          check("idle_irv", {31'b0, ir_valid}, 32'h0);
          check("idle_trap", {31'b0, trap}, 32'h0);
          check("idle_instret", instret, 32'h0);
        end
        S_FETCH: begin
          check("fetch_req", {31'b0, imem_req}, 32'h1);
          if (addr_q.size() == 0) check("addr_q_underflow", 32'h1, 32'h0);
          else begin
            check("fetch_addr", imem_addr, addr_q[0]);
            check("fetch_pc", pc, addr_q[0]);
            if (imem_ack) void'(addr_q.pop_front());
          end
        end
        S_DECODE: begin
          check("dec_irv", {31'b0, ir_valid}, 32'h1);
          check("dec_trap", {31'b0, trap}, 32'h0);
          if (ir_q.size() == 0) check("ir_q_underflow", 32'h1, 32'h0);
          else check("dec_ir", ir, ir_q.pop_front());
        end
        S_EXEC: begin
          check("exec_irv", {31'b0, ir_valid}, 32'h0);
          check("exec_req", {31'b0, imem_req}, 32'h0);
        end
        S_UPDATE: begin
          if (upd_q.size() == 0) check("upd_q_underflow", 32'h1, 32'h0);
          else begin
            upd_t u;
            u = upd_q.pop_front();
            check("upd_trap", {31'b0, trap}, {31'b0, u.trap});
            check("upd_instret", instret, u.instret);
          end
        end
        S_HALT: begin
          check("halt_req", {31'b0, imem_req}, 32'h0);
          if (halt_q.size() == 0) check("halt_q_underflow", 32'h1, 32'h0);
          else check("halt_pc", pc, halt_q.pop_front());
        end
        default: check("exp_state_bad", 32'h1, 32'h0);
      endcase
    end
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0;
    jump_en = 1'b0; jump_target = '0; halt = 1'b0;
    exp_state = S_IDLE; exp_pc = 32'h0; ret_cnt = 32'h0;
    #1 mon_en = 1'b1;
    step(); step();
    rst = 1'b0; exp_state = S_IDLE;
    step();

    do_instr(0, 0, 1'b0, 32'h0, 0);          // 0x0
    do_instr(0, 0, 1'b0, 32'h0, 0);          // 0x4
    do_instr(0, 0, 1'b0, 32'h0, 3);          // 0x8, halt for 3 cycles
    do_instr(0, 0, 1'b1, 32'h10, 0);         // 0xC, jump to pc+4
    do_instr(0, 0, 1'b1, 32'h200, 0);        // 0x10 -> 0x200
    do_instr(0, 0, 1'b1, 32'h202, 0);        // misaligned -> trap vector
    do_instr(3, 2, 1'b0, 32'h0, 0);          // 0x1000 with wait states
    do_instr(0, 0, 1'b1, 32'h40, 0);         // 0x1004 -> 0x40

    // Mid-fetch reset at pc=0x40 with imem_ack low.
    addr_q.push_back(exp_pc);
    exp_state = S_FETCH; imem_ack = 1'b0; imem_rdata = $urandom;
    step();
    #2 rst = 1'b1;
    #1;
    check("rst_state", {29'b0, state}, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_ir", ir, 32'h0);
    addr_q.delete();
    exp_state = S_IDLE;
    step(); step();
    rst = 1'b0; exp_state = S_IDLE; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    ret_cnt = 32'h0; exp_pc = 32'h0;
    step();
    imem_ack = 1'b0;

    do_instr(0, 0, 1'b1, 32'hFFFF_FFFC, 0);  // 0x0 -> top of address space
    do_instr(0, 0, 1'b0, 32'h0, 0);          // 0xFFFFFFFC wraps to 0x0
    do_instr(1, 1, 1'b0, 32'h0, 0);          // 0x0
    mon_en = 1'b0;

    check("addr_q_left", addr_q.size(), 32'h0);
    check("ir_q_left", ir_q.size(), 32'h0);
    check("upd_q_left", upd_q.size(), 32'h0);
    check("halt_q_left", halt_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Multi-cycle instruction sequencer that owns the program counter register and drives the next-PC selection for the single-issue multi-cycle core. It fetches one instruction per pass through a FETCH/DECODE/EXEC/UPDATE state machine using a req/ack handshake to instruction memory. It holds the instruction register, waits for the datapath to report completion, and then commits either PC+4 or the resolved jump target. Misaligned jump targets redirect the PC to a trap vector.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_1000, PC loaded when a misaligned jump target is committed.
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  instruction memory has valid data this cycle.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- ir  out  32  instruction register.
- ir_valid  out  1  one-cycle pulse in DECODE.
- exec_done  in  1  datapath has finished the current instruction.
- jump_en  in  1  redirect requested; sampled with exec_done.
- jump_target  in  32  redirect address; sampled with exec_done.
- halt  in  1  stop sequencing after the current instruction.
- pc  out  32  architectural PC of the current instruction.
- state  out  3  encoded FSM state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, UPDATE=4, HALT=5.
- trap  out  1  one-cycle pulse in the cycle the PC is written with TRAP_VEC.
- instret  out  32  retired-instruction count. See Configuration.

## Operation
- Reset values: state=IDLE, pc=RESET_PC, ir=0, imem_req=0, ir_valid=0, trap=0, instret=0.
- IDLE: lasts exactly one cycle, then moves to FETCH.
- FETCH: drives imem_req=1 and imem_addr=pc.
  - On imem_ack=1, ir<=imem_rdata and the FSM moves to DECODE.
  - Otherwise it stays in FETCH with the request held.
- DECODE: drives ir_valid=1 for one cycle, then moves to EXEC.
- EXEC: waits for exec_done=1.
  - In that cycle the block latches npc_q<=jump_en ? jump_target : pc+4, using 32-bit wrap-around addition (32'hFFFF_FFFC+4=0).
  - It also latches mis_q<=jump_en & (jump_target[1:0]!=0).
  - jump_en and jump_target are ignored outside an EXEC cycle with exec_done=1.
- UPDATE: pc<=mis_q ? TRAP_VEC : npc_q, and trap=mis_q.
  - The instruction counts as retired; instret increments when enabled.
  - Next state is HALT if halt=1, otherwise FETCH.
- HALT: imem_req=0 and pc holds. The FSM returns to FETCH in the cycle after halt is sampled 0.
- The halt input is sampled only in UPDATE and HALT.
- exec_done outside EXEC and imem_ack outside FETCH are ignored.
- ir holds its value outside FETCH-with-ack.

## Timing
- Minimum instruction period is 4 cycles: FETCH with same-cycle ack, DECODE, EXEC with same-cycle exec_done, UPDATE.
- Each imem wait cycle adds 1 cycle, and each cycle exec_done stays low adds 1 cycle.
- The pc output changes only on the clock edge leaving UPDATE. The new pc is visible on imem_addr in the following FETCH cycle.
- The first fetch after reset deassertion is at cycle 2, after 1 IDLE cycle.
- Async rst mid-operation immediately forces all reset values. This includes dropping imem_req and discarding any pending npc_q or mis_q. A late imem_ack after reset is ignored because the FSM is not in FETCH.
- If jump_en=1 with an aligned target equal to pc+4, the result is indistinguishable from the sequential case.

## Configuration
- PC_SEQ_CTRL_INSTRET_EN defined:
  - instret is a 32-bit counter cleared by rst.
  - It increments by 1 on every UPDATE cycle, including trapping ones, and wraps from 32'hFFFF_FFFF to 0.
- Not defined: no counter flop is built and instret is tied to 32'h0.

## Test plan
- Reset release, imem_ack tied to 1, exec_done tied to 1, jump_en=0:
  - Fetch addresses are 0x0, 0x4, 0x8, each 4 cycles apart.
  - ir_valid pulses once per instruction.
  - instret=3 after the third UPDATE when the macro is defined.
- Jump commit: at pc=0x10, exec_done=1 with jump_en=1 and jump_target=0x200:
  - The next imem_addr is 0x200 and trap=0.
- Misaligned jump: jump_target=0x202:
  - trap pulses for 1 cycle and the next imem_addr is 0x1000.
- Wait states: imem_ack delayed 3 cycles and exec_done delayed 2 cycles:
  - imem_req is held with a stable address.
  - The instruction period is 9 cycles and ir captures imem_rdata only on the ack cycle.
- Halt: halt=1 during UPDATE of the instruction at pc=0x8:
  - state becomes HALT, pc=0xC and imem_req=0 for as long as halt stays 1.
  - Fetch of 0xC starts the cycle after halt drops.
- Mid-fetch reset: assert rst while in FETCH at pc=0x40 with imem_ack low:
  - Outputs return to reset values immediately and pc=RESET_PC.
  - A stale imem_ack pulse during IDLE does not change ir.
